// File: rtl/blob_pkg.sv
// Shared definitions for the blob labelling datapath: controller states and
// default frame geometry / label table depth.
package blob_pkg;

  localparam int BLOB_IMG_W      = 640;
  localparam int BLOB_IMG_H      = 480;
  localparam int BLOB_MAX_LABELS = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_FIND    = 3'd2,
    ST_FLATTEN = 3'd3,
    ST_ACCUM   = 3'd4,
    ST_MAX     = 3'd5,
    ST_COUNT   = 3'd6,
    ST_DONE    = 3'd7
  } blob_state_e;

endpackage

// File: rtl/blob_line_buf.sv
// One-row label memory: combinational read of the previous row's label at a
// column, registered write of the current row's label at the same column.
module blob_line_buf #(
  parameter int DEPTH  = 8,
  parameter int LBL_W  = 3,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LBL_W-1:0]  wdata_i,
  output logic [LBL_W-1:0]  rdata_o
);

  logic [LBL_W-1:0] mem_q [DEPTH];

  // Read sees the old entry; a write at the same column lands on the edge.
  assign rdata_o = mem_q[addr_i];

  // Storage with frame-start clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/blob_label_counter.sv
// Streaming connected-component labeller: labels a binary frame in raster
// order, resolves label equivalences, then reports qualifying blob count.
module blob_label_counter
  import blob_pkg::*;
#(
  parameter int IMG_W        = BLOB_IMG_W,
  parameter int IMG_H        = BLOB_IMG_H,
  parameter int MAX_LABELS   = BLOB_MAX_LABELS,
  parameter int AREA_W       = 19,
  parameter int THRESH_SHIFT = 3,
  parameter int MIN_AREA     = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_valid,
  input  logic                          i_pix,
  output logic                          o_ready,
  output logic                          o_valid,
  output logic [$clog2(MAX_LABELS):0]   o_count,
  output logic [AREA_W-1:0]             o_max_area,
  output logic                          o_overflow
);

  localparam int LBL_W = $clog2(MAX_LABELS);
  localparam int NL_W  = LBL_W + 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [NL_W-1:0]   NL_FULL  = NL_W'(MAX_LABELS);
  localparam logic [NL_W-1:0]   NL_ONE   = NL_W'(1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [AREA_W-1:0] MIN_A    = AREA_W'(MIN_AREA);
  localparam logic [AREA_W-1:0] AREA_ONE = AREA_W'(1);

  function automatic logic [AREA_W-1:0] sat_add(input logic [AREA_W-1:0] a,
                                                input logic [AREA_W-1:0] b);
    logic [AREA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[AREA_W] ? {AREA_W{1'b1}} : s[AREA_W-1:0];
  endfunction

  blob_state_e       state_q, state_d;
  logic [NL_W-1:0]   next_lbl_q, next_lbl_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [LBL_W-1:0]  left_q, left_d;
  logic [LBL_W-1:0]  fa_q, fa_d, fb_q, fb_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;
  logic [NL_W-1:0]   idx_q, idx_d;
  logic [AREA_W-1:0] max_q, max_d, res_max_q, res_max_d;
  logic [NL_W-1:0]   cnt_q, cnt_d, res_cnt_q, res_cnt_d;
  logic              valid_q, ready_q;

  logic [LBL_W-1:0]  parent_q [MAX_LABELS];
  logic [AREA_W-1:0] area_q   [MAX_LABELS];

  logic              clear_s, go_find_s;
  logic              par_we_s, area_we_s, area_clr_s, lb_we_s;
  logic [LBL_W-1:0]  par_waddr_s, par_wdata_s, area_waddr_s, area_clr_addr_s;
  logic [AREA_W-1:0] area_wdata_s;
  logic [LBL_W-1:0]  lb_rdata_s, up_s, cur_s;
  logic [LBL_W-1:0]  ix_s, par_ix_s, par_par_s, par_fa_s, par_fb_s;
  logic [AREA_W-1:0] area_ix_s, area_pix_s, thr_s;

  blob_line_buf #(
    .DEPTH  (IMG_W),
    .LBL_W  (LBL_W),
    .ADDR_W (COL_W)
  ) u_line_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr_i   (clear_s),
    .we_i    (lb_we_s),
    .addr_i  (col_q),
    .wdata_i (cur_s),
    .rdata_o (lb_rdata_s)
  );

  // Row 0 has no upper neighbour; the buffer content is not trusted there.
  assign up_s       = (row_q != '0) ? lb_rdata_s : '0;
  assign ix_s       = idx_q[LBL_W-1:0];
  assign par_ix_s   = parent_q[ix_s];
  assign par_par_s  = parent_q[par_ix_s];
  assign area_ix_s  = area_q[ix_s];
  assign area_pix_s = area_q[par_ix_s];
  assign par_fa_s   = parent_q[fa_q];
  assign par_fb_s   = parent_q[fb_q];
  assign thr_s      = max_q >> THRESH_SHIFT;

  // Next-state and datapath control for the labelling controller.
  always_comb begin
    state_d         = state_q;
    next_lbl_d      = next_lbl_q;
    col_d           = col_q;
    row_d           = row_q;
    left_d          = left_q;
    fa_d            = fa_q;
    fb_d            = fb_q;
    last_d          = last_q;
    ovf_d           = ovf_q;
    idx_d           = idx_q;
    max_d           = max_q;
    cnt_d           = cnt_q;
    res_max_d       = res_max_q;
    res_cnt_d       = res_cnt_q;
    clear_s         = 1'b0;
    go_find_s       = 1'b0;
    par_we_s        = 1'b0;
    par_waddr_s     = '0;
    par_wdata_s     = '0;
    area_we_s       = 1'b0;
    area_waddr_s    = '0;
    area_wdata_s    = '0;
    area_clr_s      = 1'b0;
    area_clr_addr_s = '0;
    lb_we_s         = 1'b0;
    cur_s           = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          clear_s    = 1'b1;
          next_lbl_d = NL_ONE;
          col_d      = '0;
          row_d      = '0;
          left_d     = '0;
          last_d     = 1'b0;
          ovf_d      = 1'b0;
          res_cnt_d  = '0;
          res_max_d  = '0;
          state_d    = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (i_valid) begin
          lb_we_s = 1'b1;
          if (!i_pix) begin
            cur_s = '0;
          end else if (left_q == '0 && up_s == '0) begin
            if (next_lbl_q == NL_FULL) begin
              ovf_d = 1'b1;
            end else begin
              cur_s       = next_lbl_q[LBL_W-1:0];
              par_we_s    = 1'b1;
              par_waddr_s = cur_s;
              par_wdata_s = cur_s;
              next_lbl_d  = next_lbl_q + NL_ONE;
            end
          end else if (left_q == '0) begin
            cur_s = up_s;
          end else begin
            cur_s = left_q;
            if (up_s != '0 && up_s != left_q) begin
              go_find_s = 1'b1;
              fa_d      = left_q;
              fb_d      = up_s;
            end else begin
              go_find_s = 1'b0;
            end
          end

          // New labels start at area 0 (cleared), so one increment covers all.
          if (cur_s != '0) begin
            area_we_s    = 1'b1;
            area_waddr_s = cur_s;
            area_wdata_s = sat_add(area_q[cur_s], AREA_ONE);
          end else begin
            area_we_s = 1'b0;
          end

          if (col_q == LAST_COL) begin
            col_d  = '0;
            left_d = '0;
            if (row_q == LAST_ROW) begin
              last_d = 1'b1;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d  = col_q + COL_W'(1);
            left_d = cur_s;
          end

          if (go_find_s) begin
            state_d = ST_FIND;
          end else if (col_q == LAST_COL && row_q == LAST_ROW) begin
            state_d = ST_FLATTEN;
            idx_d   = NL_ONE;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          lb_we_s = 1'b0;
        end
      end

      ST_FIND: begin
        if (par_fa_s == fa_q && par_fb_s == fb_q) begin
          if (fa_q > fb_q) begin
            par_we_s    = 1'b1;
            par_waddr_s = fa_q;
            par_wdata_s = fb_q;
          end else if (fb_q > fa_q) begin
            par_we_s    = 1'b1;
            par_waddr_s = fb_q;
            par_wdata_s = fa_q;
          end else begin
            par_we_s = 1'b0;
          end
          if (last_q) begin
            state_d = ST_FLATTEN;
            idx_d   = NL_ONE;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          fa_d = par_fa_s;
          fb_d = par_fb_s;
        end
      end

      // Parents always point to a smaller label, so one ascending pass suffices.
      ST_FLATTEN: begin
        if (idx_q >= next_lbl_q) begin
          state_d = ST_ACCUM;
          idx_d   = next_lbl_q - NL_ONE;
        end else begin
          par_we_s    = 1'b1;
          par_waddr_s = ix_s;
          par_wdata_s = par_par_s;
          idx_d       = idx_q + NL_ONE;
        end
      end

      ST_ACCUM: begin
        if (idx_q == '0) begin
          state_d = ST_MAX;
          idx_d   = NL_ONE;
          max_d   = '0;
        end else begin
          if (par_ix_s != ix_s) begin
            area_we_s       = 1'b1;
            area_waddr_s    = par_ix_s;
            area_wdata_s    = sat_add(area_pix_s, area_ix_s);
            area_clr_s      = 1'b1;
            area_clr_addr_s = ix_s;
          end else begin
            area_we_s = 1'b0;
          end
          idx_d = idx_q - NL_ONE;
        end
      end

      ST_MAX: begin
        if (idx_q == NL_FULL) begin
          state_d = ST_COUNT;
          idx_d   = NL_ONE;
          cnt_d   = '0;
        end else begin
          if (area_ix_s > max_q) begin
            max_d = area_ix_s;
          end else begin
            max_d = max_q;
          end
          idx_d = idx_q + NL_ONE;
        end
      end

      ST_COUNT: begin
        if (idx_q == NL_FULL) begin
          res_cnt_d = cnt_q;
          res_max_d = max_q;
          state_d   = ST_DONE;
        end else begin
          if (area_ix_s > thr_s && area_ix_s >= MIN_A) begin
            cnt_d = cnt_q + NL_ONE;
          end else begin
            cnt_d = cnt_q;
          end
          idx_d = idx_q + NL_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      next_lbl_q <= NL_ONE;
      col_q      <= '0;
      row_q      <= '0;
      left_q     <= '0;
      fa_q       <= '0;
      fb_q       <= '0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
      res_max_q  <= '0;
      res_cnt_q  <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_lbl_q <= next_lbl_d;
      col_q      <= col_d;
      row_q      <= row_d;
      left_q     <= left_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
      cnt_q      <= cnt_d;
      res_max_q  <= res_max_d;
      res_cnt_q  <= res_cnt_d;
      valid_q    <= (state_d == ST_DONE);
      ready_q    <= (state_d == ST_SCAN);
    end
  end

  // Label table: parent pointers and per-label areas.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_LABELS; i++) begin
        parent_q[i] <= '0;
        area_q[i]   <= '0;
      end
    end else if (clear_s) begin
      for (int i = 0; i < MAX_LABELS; i++) begin
        parent_q[i] <= '0;
        area_q[i]   <= '0;
      end
    end else begin
      if (par_we_s) parent_q[par_waddr_s] <= par_wdata_s;
      if (area_clr_s) area_q[area_clr_addr_s] <= '0;
      if (area_we_s) area_q[area_waddr_s] <= area_wdata_s;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_count    = res_cnt_q;
  assign o_max_area = res_max_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_blob_label_counter.sv
// Directed plus randomized frames for blob_label_counter, checked against a
// flood-fill reference model of the labelled foreground.
module tb_blob_label_counter;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int ML = 8;
  localparam int TS = 1;
  localparam int MA = 1;
  localparam int NP = W * H;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_pix = 1'b0;
  logic        o_ready, o_valid, o_overflow;
  logic [3:0]  o_count;
  logic [18:0] o_max_area;

  int n_assert = 0;
  int n_fail   = 0;
  int last_nr  = 0;

  blob_label_counter #(
    .IMG_W(W), .IMG_H(H), .MAX_LABELS(ML), .AREA_W(19),
    .THRESH_SHIFT(TS), .MIN_AREA(MA)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid),
    .i_pix(i_pix), .o_ready(o_ready), .o_valid(o_valid), .o_count(o_count),
    .o_max_area(o_max_area), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pixels survive unless they need a fresh label once ML-1 are in use;
  // blobs are then the 4-connected components of the surviving pixels.
  task automatic model(input logic [31:0] img, output int ec, output int em, output bit eo);
    bit kept [NP];
    bit seen [NP];
    int sizes[$];
    int q[$];
    int used, x, r, c, sz;
    used = 0; eo = 1'b0; ec = 0; em = 0;
    for (int p = 0; p < NP; p++) begin
      kept[p] = 1'b0; seen[p] = 1'b0;
      if (img[p]) begin
        r = p / W; c = p % W;
        if ((c > 0 && kept[p-1]) || (r > 0 && kept[p-W])) kept[p] = 1'b1;
        else if (used < ML - 1) begin kept[p] = 1'b1; used++; end
        else eo = 1'b1;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (kept[p] && !seen[p]) begin
        seen[p] = 1'b1; q.push_back(p); sz = 0;
        while (q.size() > 0) begin
          x = q.pop_front(); sz++; r = x / W; c = x % W;
          if (c > 0     && kept[x-1] && !seen[x-1]) begin seen[x-1] = 1'b1; q.push_back(x-1); end
          if (c < W - 1 && kept[x+1] && !seen[x+1]) begin seen[x+1] = 1'b1; q.push_back(x+1); end
          if (r > 0     && kept[x-W] && !seen[x-W]) begin seen[x-W] = 1'b1; q.push_back(x-W); end
          if (r < H - 1 && kept[x+W] && !seen[x+W]) begin seen[x+W] = 1'b1; q.push_back(x+W); end
        end
        sizes.push_back(sz);
      end
    end
    foreach (sizes[i]) if (sizes[i] > em) em = sizes[i];
    foreach (sizes[i]) if (sizes[i] > (em >> TS) && sizes[i] >= MA) ec++;
  endtask

  task automatic start_frame();
    @(negedge i_clk);
    i_start = 1'b1; i_valid = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Offers n pixels with optional valid gaps; counts cycles with o_ready low.
  task automatic feed(input logic [31:0] img, input int n, input bit rnd, input bit poke, output int nr);
    int p = 0;
    int guard = 0;
    bit v, acc, poked;
    nr = 0; poked = 1'b0;
    while (p < n && guard < 2000) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_valid = v; i_pix = img[p];
      if (poke && p == 10 && !poked) begin i_start = 1'b1; poked = 1'b1; end
      acc = v && o_ready;
      if (!o_ready) nr++;
      @(negedge i_clk);
      i_start = 1'b0;
      guard++;
      if (acc) p++;
    end
    check("feed_budget", (p == n), 1);
  endtask

  task automatic collect(input string name, input int ec, input int em, input bit eo);
    int guard = 0;
    logic [3:0] held;
    while (!o_valid && guard < 400) begin
      i_valid = 1'b1; i_pix = 1'b1;
      @(negedge i_clk);
      guard++;
    end
    check({name, "_valid"}, o_valid, 1);
    check({name, "_count"}, o_count, ec);
    check({name, "_max"}, o_max_area, em);
    check({name, "_ovf"}, o_overflow, eo);
    held = o_count;
    @(negedge i_clk);
    i_valid = 1'b0;
    check({name, "_pulse"}, o_valid, 0);
    check({name, "_hold"}, o_count, ec);
  endtask

  task automatic run_frame(input string name, input logic [31:0] img, input bit rnd, input bit poke);
    int ec, em, nr;
    bit eo;
    model(img, ec, em, eo);
    start_frame();
    feed(img, NP, rnd, poke, nr);
    collect(name, ec, em, eo);
    last_nr = nr;
  endtask

  initial begin
    int nr;
    logic [31:0] img;
    #22;
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_max", o_max_area, 0);
    check("rst_ovf", o_overflow, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("idle_ready", o_ready, 0);

    run_frame("zero", 32'h0000_0000, 1'b0, 1'b0);
    check("zero_cnt_const", o_count, 0);
    run_frame("squares", {8'h00, 8'h00, 8'h33, 8'h33}, 1'b0, 1'b0);
    check("squares_cnt_const", o_count, 2);
    run_frame("ushape", {8'h0F, 8'h09, 8'h09, 8'h09}, 1'b0, 1'b0);
    check("ushape_ready_drop", (last_nr >= 1), 1);
    check("ushape_max_const", o_max_area, 10);
    run_frame("isolated", {8'h00, 8'h55, 8'h00, 8'h55}, 1'b0, 1'b0);
    check("isolated_cnt_const", o_count, 7);
    check("isolated_ovf_const", o_overflow, 1);
    run_frame("big_small", {8'hE0, 8'h00, 8'h0F, 8'h0F}, 1'b0, 1'b0);
    check("big_small_cnt_const", o_count, 1);
    run_frame("start_ignored", {8'h0F, 8'h09, 8'h09, 8'h09}, 1'b1, 1'b1);
    run_frame("spiral", {8'hFF, 8'h81, 8'hBD, 8'hA5}, 1'b1, 1'b0);

    // Reset in the middle of row 2 after the table has overflowed.
    start_frame();
    feed({8'hAA, 8'h55, 8'hAA, 8'h55}, 20, 1'b0, 1'b0, nr);
    check("mid_ovf_live", o_overflow, 1);
    check("mid_ready", o_ready, 1);
    i_rst_n = 1'b0;
    #2;
    check("mid_rst_ready", o_ready, 0);
    check("mid_rst_ovf", o_overflow, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_count", o_count, 0);
    check("mid_rst_max", o_max_area, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_valid = 1'b0;
    @(negedge i_clk);
    run_frame("post_rst", {8'h00, 8'h18, 8'h18, 8'h00}, 1'b0, 1'b0);
    check("post_rst_cnt_const", o_count, 1);
    check("post_rst_max_const", o_max_area, 4);

    for (int f = 0; f < 24; f++) begin
      case (f % 3)
        0:       img = $urandom & $urandom;
        1:       img = $urandom;
        default: img = $urandom | $urandom;
      endcase
      run_frame("rand", img, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/blob_label_counter.md
BLOB_LABEL_COUNTER -- requirements
Module: blob_label_counter

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 480, rows per frame.
REQ-003 SHALL have parameter MAX_LABELS, default 256, label table depth; label 0 is background.
REQ-004 SHALL have parameter AREA_W, default 19, area counter width.
REQ-005 SHALL have parameter THRESH_SHIFT, default 3; a blob counts if area > max_area >> THRESH_SHIFT.
REQ-006 SHALL have parameter MIN_AREA, default 1; a blob counts only if area >= MIN_AREA.
REQ-007 i_clk  in  1  clock, rising edge.
REQ-008 i_rst_n  in  1  reset: asynchronous, active-low.
REQ-009 i_start  in  1  one-cycle frame start; accepted only in IDLE.
REQ-010 i_valid  in  1  pixel valid.
REQ-011 i_pix  in  1  binary pixel, 1 = foreground.
REQ-012 o_ready  out  1  pixel accepted when i_valid && o_ready.
REQ-013 o_valid  out  1  one-cycle result strobe.
REQ-014 o_count  out  $clog2(MAX_LABELS)+1  qualifying blob count.
REQ-015 o_max_area  out  AREA_W  largest resolved blob area.
REQ-016 o_overflow  out  1  label table exhausted during the frame.

Function
REQ-017 States SHALL be IDLE, SCAN, FIND, FLATTEN, ACCUM, MAX, COUNT, DONE.
REQ-018 IDLE: o_ready=0; on i_start, clear table, areas, line buffer and pixel counters, then go to SCAN.
REQ-019 SCAN: o_ready=1; raster order with 4-connectivity (left and up neighbours); all neighbours outside the image read as label 0.
REQ-020 Label assignment:
- both neighbours 0: new label next_lbl, parent[next_lbl]=next_lbl, area=1, next_lbl++.
- one neighbour nonzero, or both equal: reuse that label, area+1.
- both nonzero and different: reuse the left label, area+1, go to FIND.
REQ-021 FIND: o_ready=0; walk parent pointers of the left and up labels, one step each per cycle, until both reach a root (parent[x]==x).
- Then write parent[max root]=min root; if the roots are equal, write nothing.
- Then return to SCAN.
REQ-022 A line buffer of IMG_W entries SHALL store the provisional label of each pixel written in the previous row; the stored label is not rewritten to its root.
REQ-023 Label exhaustion (next_lbl==MAX_LABELS when a new label is needed): pixel treated as background (label 0, no area), o_overflow set sticky until the next i_start.
REQ-024 After accepting pixel IMG_W*IMG_H, go to FLATTEN; further i_valid is ignored (o_ready=0).
REQ-025 FLATTEN: for i = 1..next_lbl-1 ascending, parent[i]=parent[parent[i]]; one label per cycle.
REQ-026 ACCUM: for i = next_lbl-1..1 descending, if parent[i]!=i then area[parent[i]] += area[i] and area[i]=0; one label per cycle.
REQ-027 MAX: scan all labels for the maximum area; one label per cycle.
REQ-028 COUNT: count labels with area > (max >> THRESH_SHIFT) and area >= MIN_AREA; one label per cycle.
REQ-029 DONE: o_valid=1 for exactly one cycle; o_count, o_max_area and o_overflow are valid in that cycle and held until the next i_start; then go to IDLE.
REQ-030 Area adds SHALL saturate at 2^AREA_W-1; o_count cannot exceed MAX_LABELS-1.
REQ-031 i_start outside IDLE SHALL be ignored.
REQ-032 An all-zero frame SHALL produce o_count=0 and o_max_area=0.

Reset
REQ-033 Asynchronous assertion SHALL force IDLE at any point in a frame, including mid-SCAN and mid-FIND.
- o_valid=0, o_ready=0, o_count=0, o_max_area=0, o_overflow=0.
- next_lbl=1, table and line buffer cleared.
- The interrupted frame is discarded.

Structure
REQ-034 State enum and the default IMG_W, IMG_H and MAX_LABELS constants SHALL live in shared package blob_pkg.
REQ-035 The line buffer SHALL be a sub-module blob_line_buf: IMG_W deep, label-wide, with read-before-write at the same column.

Verification (IMG_W=8, IMG_H=4, MAX_LABELS=8, THRESH_SHIFT=1, MIN_AREA=1)
REQ-036 All-zero frame -> o_valid pulse; o_count=0, o_max_area=0, o_overflow=0.
REQ-037 Two separate 2x2 squares -> o_count=2, o_max_area=4.
REQ-038 U-shape, two arms joined on the bottom row (area 10) -> o_ready drops at least 1 cycle at the join; o_count=1, o_max_area=10.
REQ-039 Eight isolated single pixels -> o_overflow=1; 7 labels used; o_count=7.
REQ-040 Blob of 8 plus blob of 3 -> o_count=1, since 3 is not > 4.
REQ-041 i_rst_n pulsed low mid-row 2, then a fresh frame with one 2x2 square -> o_count=1 with no stale labels.
